// File: rtl/bus_pkg.sv
// bus_pkg: shared read-sequencer state type and bus constants
package bus_pkg;
  localparam int DATA_W = 16;
  localparam int DEFAULT_NUM_SRC = 8;
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} bus_rd_state_t;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: index plus enable to one-hot select, all-zero when disabled or index out of range
module onehot_dec #(
  parameter int W = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          en,
  input  logic [IW-1:0] idx,
  output logic [W-1:0]  y
);
  always_comb begin
    y = '0;
    for (int i = 0; i < W; i++) y[i] = en && idx == IW'(i);
  end
endmodule

// File: rtl/bus_read_seq.sv
// bus_read_seq: enables one bus source, waits SETTLE cycles, captures the bus and returns it over valid/ready
module bus_read_seq
  import bus_pkg::*;
#(
  parameter int N = DATA_W,
  parameter int NUM_SRC = DEFAULT_NUM_SRC,
  parameter int SETTLE = 1,
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [IW-1:0]      req_idx,
  output logic [NUM_SRC-1:0] bus_en,
  input  logic [N-1:0]       bus_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_data,
  output logic [IW-1:0]      rsp_idx,
  output logic               rsp_err,
  output logic               busy
);
  localparam logic [3:0] SL = 4'(SETTLE - 1);
  bus_rd_state_t state, nxt;
  logic [IW-1:0] idx;
  logic [3:0] cnt;
  logic oor;
  assign oor = 32'(req_idx) >= NUM_SRC;
  assign req_ready = state == IDLE;
  assign busy = !req_ready;
  assign rsp_valid = state == RESP;
  onehot_dec #(.W(NUM_SRC), .IW(IW)) u_dec (
    .en(state == DRIVE || state == CAPTURE),
    .idx(idx),
    .y(bus_en)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (req_valid) nxt = oor ? RESP : (SETTLE == 0 ? CAPTURE : DRIVE);
      DRIVE:   if (cnt == SL) nxt = CAPTURE;
      CAPTURE: nxt = RESP;
      RESP:    if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // out-of-range requests skip the bus entirely and answer with an error response
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      rsp_data <= '0;
      rsp_idx <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == DRIVE) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && req_valid) begin
        idx <= req_idx;
        if (oor) begin
          rsp_data <= '0;
          rsp_idx <= req_idx;
          rsp_err <= 1'b1;
        end
      end
      if (state == CAPTURE) begin
        rsp_data <= bus_data;
        rsp_idx <= idx;
        rsp_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bus_read_seq.sv
// tb_bus_read_seq: default, SETTLE=0, SETTLE=3 and NUM_SRC=6 builds checked against a transaction-timeline model
module tb_bus_read_seq;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  function automatic int st(int g); return g == 1 ? 0 : g == 2 ? 3 : 1; endfunction
  function automatic int ns(int g); return g == 3 ? 6 : 8; endfunction
  typedef struct packed {logic [15:0] d; logic [2:0] x; logic e;} rsp_t;
  logic rv [4] = '{default: 1'b0};
  logic rr [4] = '{default: 1'b1};
  logic [2:0] ri [4] = '{default: 3'd0};
  logic qr [4], vld [4], err [4], bsy [4];
  logic [7:0] be [4];
  logic [15:0] dat [4];
  logic [2:0] rx [4];
  logic [15:0] src [8];
  int vec = 0, miss = 0;
  bit go = 1'b0;
  rsp_t q [$];
  int nrsp [4] = '{default: 0};
  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [ns(g)-1:0] e;
    logic [15:0] bd;
    always_comb begin
      bd = 16'hzzzz;
      for (int s = 0; s < 8; s++) if (be[g][s]) bd = src[s];
    end
    bus_read_seq #(.N(16), .NUM_SRC(ns(g)), .SETTLE(st(g))) dut (
      .clk(clk), .reset(reset), .req_valid(rv[g]), .req_ready(qr[g]), .req_idx(ri[g]),
      .bus_en(e), .bus_data(bd), .rsp_valid(vld[g]), .rsp_ready(rr[g]), .rsp_data(dat[g]),
      .rsp_idx(rx[g]), .rsp_err(err[g]), .busy(bsy[g]));
    assign be[g] = 8'(e);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    vec++;
    if (a !== x) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", n, a, x);
    end
  endtask
  // model: a read accepted at edge E0 enables its source for SETTLE+1 cycles, then
  // responds with whatever that source drove in the last enabled cycle
  logic m_busy [4], m_val [4], m_err [4];
  logic [2:0] m_idx [4], m_rx [4];
  logic [15:0] m_dat [4];
  int m_t [4];
  int m_acc [4] = '{default: 0};
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (reset) begin
        m_busy[i] <= 1'b0; m_val[i] <= 1'b0; m_err[i] <= 1'b0;
        m_rx[i] <= '0; m_dat[i] <= '0; m_idx[i] <= '0; m_t[i] <= 0;
      end else if (!m_busy[i]) begin
        if (rv[i]) begin
          m_busy[i] <= 1'b1; m_idx[i] <= ri[i]; m_t[i] <= 0; m_acc[i] <= m_acc[i] + 1;
          if (int'(ri[i]) >= ns(i)) begin
            m_val[i] <= 1'b1; m_err[i] <= 1'b1; m_dat[i] <= '0; m_rx[i] <= ri[i];
          end
        end
      end else if (m_val[i]) begin
        if (rr[i]) begin m_val[i] <= 1'b0; m_busy[i] <= 1'b0; end
      end else begin
        m_t[i] <= m_t[i] + 1;
        if (m_t[i] == st(i)) begin
          m_val[i] <= 1'b1; m_err[i] <= 1'b0; m_dat[i] <= src[m_idx[i]]; m_rx[i] <= m_idx[i];
        end
      end
  always @(posedge clk) begin
    #1;
    if (go)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("req_ready[%0d]", i), 32'(qr[i]), 32'(!m_busy[i]));
        chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(m_busy[i]));
        chk($sformatf("rsp_valid[%0d]", i), 32'(vld[i]), 32'(m_val[i]));
        chk($sformatf("bus_en[%0d]", i), 32'(be[i]), 32'((m_busy[i] && !m_val[i]) ? 8'h1 << m_idx[i] : 8'h0));
        if (m_val[i]) begin
          chk($sformatf("rsp_data[%0d]", i), 32'(dat[i]), 32'(m_dat[i]));
          chk($sformatf("rsp_idx[%0d]", i), 32'(rx[i]), 32'(m_rx[i]));
          chk($sformatf("rsp_err[%0d]", i), 32'(err[i]), 32'(m_err[i]));
        end
        vec++;
        assert ($onehot0(be[i])) else begin
          miss++;
          $display("FAIL onehot0[%0d]: bus_en=%b", i, be[i]);
        end
      end
  end
  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (!reset && vld[i] && rr[i]) begin
        nrsp[i]++;
        if (i == 0) q.push_back({dat[i], rx[i], err[i]});
      end
  task automatic xact(input int i, input logic [2:0] x, input int hold,
                      output int en, output int lat, output logic [15:0] d, output logic e);
    en = 0;
    lat = -1;
    rr[i] = 1'b0; rv[i] = 1'b1; ri[i] = x;
    @(posedge clk); #1;
    rv[i] = 1'b0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (be[i] != 8'h0) en++;
      if (vld[i]) lat = k;
      else begin @(posedge clk); #1; end
    end
    if (lat < 0) chk($sformatf("timeout[%0d]", i), 32'(lat), 32'(0));
    d = dat[i];
    e = err[i];
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold req_ready", 32'(qr[i]), 0);
      chk("hold bus_en", 32'(be[i]), 0);
      chk("hold rsp_valid", 32'(vld[i]), 1);
    end
    rr[i] = 1'b1;
    @(posedge clk); #1;
    chk("after handshake req_ready", 32'(qr[i]), 1);
    chk("after handshake rsp_valid", 32'(vld[i]), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int en, lat, a, n0;
    logic [15:0] d;
    logic e;
    for (int s = 0; s < 8; s++) src[s] = 16'(16'h1111 * s);
    @(posedge clk); @(posedge clk); #1;
    go = 1'b1;
    reset = 1'b0;
    chk("reset req_ready", 32'(qr[0]), 1);
    chk("reset rsp_valid", 32'(vld[0]), 0);
    chk("reset bus_en", 32'(be[0]), 0);
    chk("reset busy", 32'(bsy[0]), 0);
    chk("reset rsp_data", 32'(dat[0]), 0);
    src[3] = 16'hA5C3;
    xact(0, 3'd3, 5, en, lat, d, e);
    chk("u0 idx3 enable cycles", en, 2);
    chk("u0 idx3 edges to valid", lat, 2);
    chk("u0 idx3 data", 32'(d), 32'hA5C3);
    chk("u0 idx3 err", 32'(e), 0);
    chk("u0 idx3 rsp_idx held", 32'(rx[0]), 3);
    chk("model pin idx3 data", 32'(m_dat[0]), 32'hA5C3);
    src[0] = 16'hFFFF;
    xact(1, 3'd0, 0, en, lat, d, e);
    chk("settle0 enable cycles", en, 1);
    chk("settle0 edges to valid", lat, 1);
    chk("settle0 data", 32'(d), 32'hFFFF);
    xact(2, 3'd0, 0, en, lat, d, e);
    chk("settle3 enable cycles", en, 4);
    chk("settle3 edges to valid", lat, 4);
    chk("settle3 data", 32'(d), 32'hFFFF);
    xact(3, 3'd7, 2, en, lat, d, e);
    chk("n6 idx7 enable cycles", en, 0);
    chk("n6 idx7 edges to valid", lat, 0);
    chk("n6 idx7 data", 32'(d), 0);
    chk("n6 idx7 err", 32'(e), 1);
    src[5] = 16'h0F0F;
    xact(3, 3'd5, 0, en, lat, d, e);
    chk("n6 idx5 data", 32'(d), 32'h0F0F);
    chk("n6 idx5 err", 32'(e), 0);
    src[7] = 16'h7E57;
    xact(0, 3'd7, 1, en, lat, d, e);
    chk("u0 idx7 enable cycles", en, 2);
    chk("u0 idx7 data", 32'(d), 32'h7E57);
    n0 = nrsp[0];
    src[5] = 16'h5A5A;
    rr[0] = 1'b1; rv[0] = 1'b1; ri[0] = 3'd5;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    chk("drive idx5 bus_en", 32'(be[0]), 32'h20);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset in drive bus_en", 32'(be[0]), 0);
    chk("reset in drive rsp_valid", 32'(vld[0]), 0);
    chk("reset in drive req_ready", 32'(qr[0]), 1);
    repeat (8) @(posedge clk);
    #1;
    chk("abandoned read responses", nrsp[0] - n0, 0);
    q.delete();
    src[1] = 16'h0001;
    src[2] = 16'h8000;
    a = m_acc[0];
    rr[0] = 1'b1; ri[0] = 3'd1; rv[0] = 1'b1;
    for (int k = 0; k < 80 && q.size() < 3; k++) begin
      @(posedge clk); #1;
      if (m_acc[0] == a + 1) ri[0] = 3'd2;
      if (m_acc[0] == a + 2) begin ri[0] = 3'd1; src[1] = 16'h1234; end
      if (m_acc[0] >= a + 3) rv[0] = 1'b0;
    end
    rv[0] = 1'b0;
    chk("b2b response count", q.size(), 3);
    if (q.size() == 3) begin
      chk("b2b r0 data", 32'(q[0].d), 32'h0001);
      chk("b2b r0 idx", 32'(q[0].x), 1);
      chk("b2b r1 data", 32'(q[1].d), 32'h8000);
      chk("b2b r1 idx", 32'(q[1].x), 2);
      chk("b2b r2 data", 32'(q[2].d), 32'h1234);
      chk("b2b r2 idx", 32'(q[2].x), 1);
    end
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/bus_read_seq.md
Name: bus_read_seq

Overview:
- Read-side sequencer for the shared 16-bit tristate data bus driven by the team's enable-gated storage registers; a source releases the bus to high-Z when its enable is low.
- Accepts a read request for a source index and asserts exactly one source enable. It waits a settle interval, captures the bus value, then returns it over a valid/ready response channel.
- Sits between the control unit/debug readback logic and the register bank. It is the only block permitted to drive register enables for bus reads.

Parameters:
- N, 16, data/bus width in bits
- NUM_SRC, 8, number of bus sources (enable lines)
- SETTLE, 1, cycles bus_en is held before the capture cycle (0..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  read request present
- req_ready  out  1  sequencer can accept a request (high only in IDLE)
- req_idx  in  $clog2(NUM_SRC) (min 1)  source to read
- bus_en  out  NUM_SRC  one-hot source enables to register bank
- bus_data  in  N  shared tristate bus
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  N  captured bus value
- rsp_idx  out  $clog2(NUM_SRC)  index the response belongs to
- rsp_err  out  1  request index out of range (valid with rsp_valid)
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, DRIVE, CAPTURE, RESP.
- Reset, applied synchronously in any state: state=IDLE, bus_en=0, rsp_valid=0, rsp_data=0, rsp_idx=0, rsp_err=0, settle counter=0, busy=0. An in-flight read is abandoned and no response is produced.
- IDLE: req_ready=1, bus_en=0. On req_valid&req_ready, latch req_idx.
  - If req_idx >= NUM_SRC, go to RESP with rsp_err=1 and rsp_data=0. bus_en is never asserted for this request.
  - Otherwise go to DRIVE, or to CAPTURE when SETTLE=0. Clear the counter.
- DRIVE: bus_en[idx]=1. The counter increments each cycle, and the state moves to CAPTURE after SETTLE cycles in DRIVE.
- CAPTURE: bus_en[idx]=1 for one cycle. At the closing edge, rsp_data<=bus_data, rsp_idx<=idx, rsp_err<=0, and the state goes to RESP.
- RESP: bus_en=0 and rsp_valid=1. rsp_data, rsp_idx and rsp_err stay stable until rsp_valid&rsp_ready; at that edge rsp_valid goes to 0 and the state returns to IDLE.
- Latency: accept at edge E0; bus_en high for SETTLE+1 cycles starting after E0; rsp_valid rises after edge E0+SETTLE+1. With the default, rsp_valid is high in the 3rd cycle after acceptance.
- Throughput: a new request is accepted no earlier than the cycle after the response handshake. req_ready=0 whenever busy=1. Requests presented while busy are not consumed and the requester must hold them.
- Invariant: bus_en is all-zero or has exactly one bit set. It is never non-zero in IDLE or RESP, and it changes only at clock edges.
- Response outputs hold their last values between transactions. rsp_valid is the only qualifier.
- Capture uses the value present in the CAPTURE cycle. X/Z on bus_data is passed through unchanged; no checking is done.
- Simultaneous req_valid and rsp_ready in RESP: the response completes and the request waits for IDLE.
- SETTLE counter width is 4 bits.

Decomposition:
- Shared package bus_pkg holds:
  - state enum bus_rd_state_t {IDLE, DRIVE, CAPTURE, RESP}
  - DATA_W=16 and DEFAULT_NUM_SRC=8 constants
- One natural sub-module: onehot_dec. It maps index plus enable to a NUM_SRC-bit one-hot vector, outputs zero when disabled or out of range, and is reused by the write-side control.

Test Plan:
- Default params; source 3 drives 16'hA5C3 while bus_en[3]=1 and Z otherwise. Request idx=3 -> bus_en=8'b0000_1000 for exactly 2 cycles, rsp_valid in cycle 3 after accept, rsp_data=16'hA5C3, rsp_idx=3, rsp_err=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_idx stable, req_ready=0, bus_en=0 throughout. rsp_ready=1 -> next edge gives IDLE, req_ready=1.
- NUM_SRC=6, request idx=7 -> no bus_en bit ever set, rsp_valid after 1 cycle, rsp_err=1, rsp_data=16'h0000.
- Reset asserted in DRIVE during idx=5 read -> next edge bus_en=0, rsp_valid=0, req_ready=1. No response is ever emitted for idx=5.
- SETTLE=0 and SETTLE=3 builds, idx=0 reading 16'hFFFF -> bus_en high for 1 and 4 cycles respectively, rsp_data=16'hFFFF.
- Back-to-back reads idx 1 (16'h0001), 2 (16'h8000), 1 (16'h1234), with req_valid held high and rsp_ready=1 -> three responses in order with matching data. An assertion checks that $onehot0(bus_en) holds every cycle.
